// File: rtl/cnn_accelerator_mac_pkg.sv
// Shared types and width helpers for the CNN accelerator multiply-accumulate pipeline.
package cnn_accelerator_mac_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } acc_state_t;

   typedef struct packed {
      logic first;
      logic last;
   } sideband_t;

   // Product width: both operands grow by one extension bit before the multiply.
   function automatic int p_width(input int din0_width, input int din1_width);
      return din0_width + din1_width + 2;
   endfunction

   function automatic logic signed [63:0] acc_max(input int acc_width);
      return (64'sd1 <<< (acc_width - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] acc_min(input int acc_width);
      return -(64'sd1 <<< (acc_width - 1));
   endfunction

endpackage

// File: rtl/cnn_accelerator_mul_pipe.sv
// Operand extension, signed product and NUM_STAGE-deep product register chain with
// valid/sideband; every register advances only while en is high.
module cnn_accelerator_mul_pipe
   import cnn_accelerator_mac_pkg::*;
#(
   parameter int DIN0_WIDTH = 5,
   parameter int DIN1_WIDTH = 7,
   parameter int NUM_STAGE  = 2,
   parameter int P          = p_width(DIN0_WIDTH, DIN1_WIDTH)
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  en,
   input  logic                  in_valid,
   input  logic [DIN0_WIDTH-1:0] din0,
   input  logic [DIN1_WIDTH-1:0] din1,
   input  logic                  signed0,
   input  logic                  signed1,
   input  sideband_t             in_sb,
   output logic                  prod_valid,
   output logic signed [P-1:0]   prod,
   output sideband_t             prod_sb
);

   logic signed [DIN0_WIDTH:0] a_q;
   logic signed [DIN1_WIDTH:0] b_q;
   sideband_t                  op_sb_q;
   logic                       op_valid_q;
   logic signed [P-1:0]        prod_c;
   logic signed [P-1:0]        prod_q [NUM_STAGE];
   sideband_t                  sb_q   [NUM_STAGE];
   logic [NUM_STAGE-1:0]       vld_q;

   assign prod_c = a_q * b_q;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         op_valid_q <= 1'b0;
         vld_q      <= '0;
      end else if (en) begin
         op_valid_q <= in_valid;
         vld_q[0]   <= op_valid_q;
         for (int s = 1; s < NUM_STAGE; s++) begin
            vld_q[s] <= vld_q[s-1];
         end
      end
   end

   // NOTE: operand, product and sideband registers carry no reset; the valid bits
   // above are the only state that decides whether their contents are ever used.
   always_ff @(posedge ap_clk) begin
      if (en) begin
         a_q       <= {signed0 & din0[DIN0_WIDTH-1], din0};
         b_q       <= {signed1 & din1[DIN1_WIDTH-1], din1};
         op_sb_q   <= in_sb;
         prod_q[0] <= prod_c;
         sb_q[0]   <= op_sb_q;
         for (int s = 1; s < NUM_STAGE; s++) begin
            prod_q[s] <= prod_q[s-1];
            sb_q[s]   <= sb_q[s-1];
         end
      end
   end

   assign prod_valid = vld_q[NUM_STAGE-1];
   assign prod       = prod_q[NUM_STAGE-1];
   assign prod_sb    = sb_q[NUM_STAGE-1];

endmodule

// File: rtl/cnn_accelerator_mac_pipe.sv
// Pipelined multiply-accumulate with per-beat signedness, saturating signed accumulation
// over first/last-delimited streams, and valid/ready handshakes on both sides.
module cnn_accelerator_mac_pipe
   import cnn_accelerator_mac_pkg::*;
#(
   parameter int DIN0_WIDTH = 5,
   parameter int DIN1_WIDTH = 7,
   parameter int ACC_WIDTH  = 20,
   parameter int NUM_STAGE  = 2
) (
   input  logic                        ap_clk,
   input  logic                        ap_rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [DIN0_WIDTH-1:0]       din0,
   input  logic [DIN1_WIDTH-1:0]       din1,
   input  logic                        signed0,
   input  logic                        signed1,
   input  logic                        first,
   input  logic                        last,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [ACC_WIDTH-1:0] dout,
   output logic                        sat
);

   localparam int                        P         = p_width(DIN0_WIDTH, DIN1_WIDTH);
   localparam logic signed [63:0]        ACC_MAX64 = acc_max(ACC_WIDTH);
   localparam logic signed [63:0]        ACC_MIN64 = acc_min(ACC_WIDTH);
   localparam logic signed [ACC_WIDTH:0] SUM_MAX   = ACC_MAX64[ACC_WIDTH:0];
   localparam logic signed [ACC_WIDTH:0] SUM_MIN   = ACC_MIN64[ACC_WIDTH:0];

   logic                        en;
   sideband_t                   in_sb;
   logic                        prod_valid;
   logic signed [P-1:0]         prod;
   sideband_t                   prod_sb;
   logic signed [ACC_WIDTH:0]   prod_ext;
   logic signed [ACC_WIDTH:0]   base;
   logic signed [ACC_WIDTH:0]   sum;
   logic signed [ACC_WIDTH-1:0] clamped;
   logic                        clamp;
   logic                        restart;
   logic                        take;
   logic                        complete;
   acc_state_t                  state_q, state_d;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic                        sat_acc_q, sat_acc_d;

   // The whole pipeline freezes while a finished result waits for the consumer.
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   assign in_sb.first = first;
   assign in_sb.last  = last;

   cnn_accelerator_mul_pipe #(
      .DIN0_WIDTH (DIN0_WIDTH),
      .DIN1_WIDTH (DIN1_WIDTH),
      .NUM_STAGE  (NUM_STAGE),
      .P          (P)
   ) u_mul_pipe (
      .ap_clk     (ap_clk),
      .ap_rst_n   (ap_rst_n),
      .en         (en),
      .in_valid   (in_valid),
      .din0       (din0),
      .din1       (din1),
      .signed0    (signed0),
      .signed1    (signed1),
      .in_sb      (in_sb),
      .prod_valid (prod_valid),
      .prod       (prod),
      .prod_sb    (prod_sb)
   );

   // ACC_WIDTH >= P keeps this replication at least one bit wide.
   assign prod_ext = {{(ACC_WIDTH + 1 - P){prod[P-1]}}, prod};
   assign take     = en && prod_valid;
   assign complete = take && prod_sb.last;

   // NOTE: every variable written here gets its default first, so no path through
   // the block leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      sat_acc_d = sat_acc_q;
      restart   = prod_sb.first || (state_q == IDLE);
      base      = restart ? '0 : {acc_q[ACC_WIDTH-1], acc_q};
      sum       = base + prod_ext;
      clamp     = 1'b0;
      clamped   = sum[ACC_WIDTH-1:0];
      if (sum > SUM_MAX) begin
         clamped = SUM_MAX[ACC_WIDTH-1:0];
         clamp   = 1'b1;
      end else if (sum < SUM_MIN) begin
         clamped = SUM_MIN[ACC_WIDTH-1:0];
         clamp   = 1'b1;
      end
      if (take) begin
         acc_d     = clamped;
         sat_acc_d = clamp | (!restart & sat_acc_q);
         state_d   = prod_sb.last ? IDLE : ACCUM;
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         acc_q     <= '0;
         sat_acc_q <= 1'b0;
         out_valid <= 1'b0;
         dout      <= '0;
         sat       <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         sat_acc_q <= sat_acc_d;
         // A handshake and a new completion in the same cycle keeps out_valid high.
         if (en) begin
            out_valid <= complete;
         end
         if (complete) begin
            dout <= acc_d;
            sat  <= sat_acc_d;
         end
      end
   end

endmodule

// File: tb/tb_cnn_accelerator_mac_pipe.sv
// Scoreboard bench: two instances (ACC_WIDTH 20 and 14) share all inputs; a reference
// model pushes expected results on each accepted last beat, a monitor pops on handshake.
module tb_cnn_accelerator_mac_pipe;

   localparam int NS = 2;

   logic        ap_clk    = 1'b0;
   logic        ap_rst_n  = 1'b0;
   logic        in_valid  = 1'b0;
   logic [4:0]  din0      = '0;
   logic [6:0]  din1      = '0;
   logic        signed0   = 1'b0;
   logic        signed1   = 1'b0;
   logic        first     = 1'b0;
   logic        last      = 1'b0;
   logic        out_ready = 1'b1;

   logic        in_ready_a, in_ready_b, out_valid_a, out_valid_b, sat_a, sat_b;
   logic [19:0] dout_a;
   logic [13:0] dout_b;

   cnn_accelerator_mac_pipe #(
      .DIN0_WIDTH (5), .DIN1_WIDTH (7), .ACC_WIDTH (20), .NUM_STAGE (NS)
   ) dut_a (
      .ap_clk (ap_clk), .ap_rst_n (ap_rst_n), .in_valid (in_valid), .in_ready (in_ready_a),
      .din0 (din0), .din1 (din1), .signed0 (signed0), .signed1 (signed1),
      .first (first), .last (last), .out_valid (out_valid_a), .out_ready (out_ready),
      .dout (dout_a), .sat (sat_a)
   );

   cnn_accelerator_mac_pipe #(
      .DIN0_WIDTH (5), .DIN1_WIDTH (7), .ACC_WIDTH (14), .NUM_STAGE (NS)
   ) dut_b (
      .ap_clk (ap_clk), .ap_rst_n (ap_rst_n), .in_valid (in_valid), .in_ready (in_ready_b),
      .din0 (din0), .din1 (din1), .signed0 (signed0), .signed1 (signed1),
      .first (first), .last (last), .out_valid (out_valid_b), .out_ready (out_ready),
      .dout (dout_b), .sat (sat_b)
   );

   always #5 ap_clk = ~ap_clk;

   typedef struct {
      longint d20;
      bit     s20;
      longint d14;
      bit     s14;
   } exp_t;

   exp_t   sb[$];
   int     checks = 0;
   int     errors = 0;
   bit     m_open = 1'b0;
   longint m_acc20, m_acc14;
   bit     m_sat20, m_sat14;

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic void sat_step(input int w, input longint p, input bit restart,
                                    inout longint acc, inout bit s);
      longint mx;
      longint mn;
      longint total;
      mx    = (longint'(1) << (w - 1)) - 1;
      mn    = -(longint'(1) << (w - 1));
      total = (restart ? 0 : acc) + p;
      if (restart) s = 1'b0;
      if (total > mx) begin
         total = mx;
         s     = 1'b1;
      end else if (total < mn) begin
         total = mn;
         s     = 1'b1;
      end
      acc = total;
   endfunction

   function automatic void model_beat(input logic [4:0] a, input logic [6:0] b,
                                      input bit s0, input bit s1, input bit f, input bit l);
      longint av;
      longint bv;
      longint p;
      bit     restart;
      exp_t   e;
      av      = (s0 && a[4]) ? longint'(a) - 32  : longint'(a);
      bv      = (s1 && b[6]) ? longint'(b) - 128 : longint'(b);
      p       = av * bv;
      restart = f || !m_open;
      sat_step(20, p, restart, m_acc20, m_sat20);
      sat_step(14, p, restart, m_acc14, m_sat14);
      if (l) begin
         e.d20 = m_acc20;
         e.s20 = m_sat20;
         e.d14 = m_acc14;
         e.s14 = m_sat14;
         sb.push_back(e);
      end
      m_open = !l;
   endfunction

   task automatic send_beat(input logic [4:0] a, input logic [6:0] b,
                            input bit s0, input bit s1, input bit f, input bit l);
      bit go;
      int tries;
      go    = 1'b0;
      tries = 0;
      @(negedge ap_clk);
      din0 = a; din1 = b; signed0 = s0; signed1 = s1; first = f; last = l;
      in_valid = 1'b1;
      while (!go && tries < 200) begin
         #1;
         go = in_ready_a;
         @(posedge ap_clk);
         if (!go) begin
            tries++;
            @(negedge ap_clk);
         end
      end
      if (go) begin
         model_beat(a, b, s0, s1, f, l);
      end else begin
         check("in_ready_timeout", 0, 1);
      end
      #1;
      in_valid = 1'b0;
   endtask

   // Called straight after a last beat is accepted with the output side free.
   task automatic measure_latency(input string tag);
      int n;
      n = 0;
      do begin
         @(posedge ap_clk);
         n++;
         #1;
      end while (!out_valid_a && n < 20);
      check(tag, n, NS + 1);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || out_valid_a) && n < 200) begin
         @(posedge ap_clk);
         n++;
      end
      if (n >= 200) check("drain_timeout", 0, 1);
      @(negedge ap_clk);
   endtask

   logic [19:0] prev_dout;
   bit          prev_stall = 1'b0;

   always @(negedge ap_clk) begin
      exp_t e;
      if (!ap_rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) check("dout_hold", $signed(dout_a), $signed(prev_dout));
         if (out_valid_a) begin
            check("in_ready_bp", in_ready_a, out_ready);
            check("valid_b", out_valid_b, 1);
         end
         if (out_valid_a && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_out", 1, 0);
            end else begin
               e = sb.pop_front();
               check("dout20", $signed(dout_a), e.d20);
               check("sat20", sat_a, e.s20);
               check("dout14", $signed(dout_b), e.d14);
               check("sat14", sat_b, e.s14);
            end
         end
         prev_stall = out_valid_a && !out_ready;
         prev_dout  = dout_a;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit done;
      #1;
      check("rst_out_valid", out_valid_a, 0);
      check("rst_dout", $signed(dout_a), 0);
      check("rst_sat", sat_a, 0);
      check("rst_in_ready", in_ready_a, 1);
      repeat (3) @(negedge ap_clk);
      ap_rst_n = 1'b1;

      // Unsigned single beat with latency check.
      send_beat(5'd31, 7'd127, 0, 0, 1, 1);
      measure_latency("latency_single");
      wait_drain();
      check("unsigned_dout", $signed(dout_a), 3937);

      // Mixed signedness.
      send_beat(5'b10000, 7'd127, 1, 0, 1, 1);
      wait_drain();
      check("mixed_dout_hex", dout_a, 20'hFF810);
      check("mixed_sat", sat_a, 0);

      // Four back-to-back accumulations; the 14-bit instance saturates.
      send_beat(5'd31, 7'd127, 0, 0, 1, 0);
      send_beat(5'd31, 7'd127, 0, 0, 0, 0);
      send_beat(5'd31, 7'd127, 0, 0, 0, 0);
      send_beat(5'd31, 7'd127, 0, 0, 0, 1);
      measure_latency("latency_accum");
      wait_drain();
      check("accum4_dout", $signed(dout_a), 15748);

      // Saturation on ACC_WIDTH=14, then a clean accumulation.
      send_beat(5'd31, 7'd127, 0, 0, 1, 0);
      send_beat(5'd31, 7'd127, 0, 0, 0, 0);
      send_beat(5'd31, 7'd127, 0, 0, 0, 1);
      wait_drain();
      check("sat14_dout", $signed(dout_b), 8191);
      check("sat14_flag", sat_b, 1);
      send_beat(5'd2, 7'd3, 0, 0, 1, 1);
      wait_drain();
      check("after_sat_dout", $signed(dout_b), 6);
      check("after_sat_flag", sat_b, 0);

      // Backpressure: out_ready low for 5 cycles while single-beat results stream.
      fork
         begin
            for (int i = 0; i < 6; i++) send_beat(5'(i + 1), 7'd3, 0, 0, 1, 1);
         end
         begin
            repeat (3) @(posedge ap_clk);
            #1 out_ready = 1'b0;
            repeat (5) @(posedge ap_clk);
            #1 out_ready = 1'b1;
         end
      join
      wait_drain();

      // Random operands, signedness and framing under random out_ready.
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               send_beat(5'($urandom), 7'($urandom), 1'($urandom), 1'($urandom),
                         ($urandom_range(0, 3) == 0), (i == 39) || ($urandom_range(0, 3) == 0));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge ap_clk);
               #1 out_ready = 1'($urandom);
            end
            out_ready = 1'b1;
         end
      join
      wait_drain();

      // Reset mid-accumulation discards the partial sum.
      send_beat(5'd7, 7'd9, 0, 0, 1, 0);
      send_beat(5'd7, 7'd9, 0, 0, 0, 0);
      @(negedge ap_clk);
      ap_rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid_a, 0);
      check("midrst_dout", $signed(dout_a), 0);
      check("midrst_in_ready", in_ready_a, 1);
      sb.delete();
      m_open = 1'b0;
      repeat (2) @(negedge ap_clk);
      ap_rst_n = 1'b1;
      send_beat(5'd2, 7'd3, 0, 0, 0, 1);
      wait_drain();
      check("post_rst_dout", $signed(dout_a), 6);
      check("post_rst_dout14", $signed(dout_b), 6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
